loop_nest_ctrl: RTL and testbench
=================================

Name: loop_nest_ctrl

Overview:
- Sequencer for the memory controller's nested loop counters: walks a 3-level loop nest (channel outer, row middle, column inner) and issues one index tuple per accepted handshake to the address/fetch datapath.
- Each level has its own run-time max and stride and uses the team's loop-counter semantics (advance by stride while count < max, else wrap to 0).
- Adds start/busy/done control, a valid/ready output handshake, end-of-row/end-of-pass markers and a synchronous abort.

Parameters:
- DATA_WIDTH, 4, width of every index, max and stride field.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current pass.
- cfg_max_c  in  DATA_WIDTH  channel-level max.
- cfg_stride_c  in  DATA_WIDTH  channel-level stride.
- cfg_max_r  in  DATA_WIDTH  row-level max.
- cfg_stride_r  in  DATA_WIDTH  row-level stride.
- cfg_max_w  in  DATA_WIDTH  column-level max.
- cfg_stride_w  in  DATA_WIDTH  column-level stride.
- idx_ready  in  1  downstream accepts the current tuple.
- idx_valid  out  1  tuple on idx_c/idx_r/idx_w is valid.
- idx_c  out  DATA_WIDTH  channel index.
- idx_r  out  DATA_WIDTH  row index.
- idx_w  out  DATA_WIDTH  column index.
- last_w  out  1  current tuple ends a column sweep.
- last_all  out  1  current tuple is the final tuple of the pass.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset is synchronous and active-high, with one clock (clk).
  - On reset: state = IDLE, idx_c = idx_r = idx_w = 0, idx_valid = 0, busy = 0, done = 0, config registers = 0.
  - reset overrides start and abort.
- State machine:
  - IDLE:
    - On start: latch all six cfg inputs into internal registers and clear all indices.
    - Next cycle: RUN with idx_valid = 1 and tuple (0,0,0).
    - cfg inputs are ignored outside this capture cycle.
  - RUN:
    - idx_valid stays 1; the tuple is held stable while idx_ready = 0.
    - On idx_valid & idx_ready, advance the nest once, in the same edge:
      - Column level:
        - if idx_w < max_w: idx_w <= idx_w + stride_w;
        - else idx_w <= 0 and carry to the row level.
      - Row level, on carry only: same rule with max_r/stride_r; a wrap carries to the channel level.
      - Channel level, on carry only: same rule with max_c/stride_c; a wrap ends the pass.
    - When the pass ends (accepted tuple has last_all = 1): go to DONE, idx_valid <= 0, indices <= 0.
  - DONE: done = 1 for exactly one cycle, busy = 0, then return to IDLE.
- Combinational flags:
  - last_w = (idx_w >= max_w) & idx_valid.
  - last_all = last_w & (idx_r >= max_r) & (idx_c >= max_c).
- Arithmetic and width rules:
  - Sums are computed at DATA_WIDTH+1 bits. If count + stride exceeds 2^DATA_WIDTH - 1, that level wraps and carries, exactly as in the count >= max case. last_w and last_all also assert on a tuple whose next step would overflow.
  - A stride of 0 is treated as 1.
  - A max of 0 gives that level a single iteration (index 0).
  - Issued values per level: 0, s, 2s, ..., continuing while the previous value < max. The final value may exceed max, e.g. max = 5, stride = 2 gives 0, 2, 4, 6.
- Simultaneous and boundary events:
  - start while busy or in DONE: ignored.
  - abort in RUN: next state IDLE, idx_valid = 0, indices = 0, no done pulse. Any handshake in that same cycle is discarded.
  - abort in IDLE or DONE: ignored. DONE still pulses.
  - start and abort together in IDLE: start wins (abort has no effect in IDLE).
  - Throughput: one tuple per cycle while idx_ready = 1.
  - Latency: start to first idx_valid is 1 cycle; the last accepted tuple to done is 1 cycle.

Test Plan:
- Reset then idle: hold start = 0 for 5 cycles -> idx_valid = 0, busy = 0, done = 0, indices 0.
- Basic nest: max_w = 2, stride_w = 1, max_r = 1, stride_r = 1, max_c = 0, idx_ready = 1.
  - Required: 6 tuples (c,r,w) = (0,0,0), (0,0,1), (0,0,2), (0,1,0), (0,1,1), (0,1,2) on consecutive cycles.
  - last_w on w = 2; last_all only on the 6th tuple; done pulses the next cycle.
- Stride and overflow (DATA_WIDTH = 4):
  - max_w = 5, stride_w = 2: w sequence 0, 2, 4, 6 then wrap.
  - max_w = 15, stride_w = 8: w sequence 0, 8; 8 + 8 overflows, so wrap and carry, with last_w on 8.
- Backpressure: toggle idx_ready 1,0,0,1,... in the basic nest -> the tuple is held while ready = 0, the same 6-tuple order results, and no tuple is skipped or duplicated.
- Abort mid-pass: abort at the 3rd tuple -> next cycle IDLE, idx_valid = 0, no done pulse. A fresh start then restarts from (0,0,0).
- Ignored start and config change: assert start and change cfg_max_w mid-RUN -> no restart, and the latched max is still used.

Source files
------------

// File: rtl/loop_nest_ctrl.sv
// loop_nest_ctrl: three-level (channel/row/column) loop-nest sequencer with valid/ready index output
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start, abort               begin a pass (IDLE only) / cancel a running pass
//   cfg_max_*, cfg_stride_*    per-level max and stride, captured on start
//   idx_valid, idx_ready       output handshake for the current tuple
//   idx_c, idx_r, idx_w        channel, row, column indices
//   last_w, last_all           tuple ends a column sweep / ends the pass
//   busy, done                 high while running / one-cycle pass-complete pulse
module loop_nest_ctrl #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] cfg_max_c,
    input  logic [DATA_WIDTH-1:0] cfg_stride_c,
    input  logic [DATA_WIDTH-1:0] cfg_max_r,
    input  logic [DATA_WIDTH-1:0] cfg_stride_r,
    input  logic [DATA_WIDTH-1:0] cfg_max_w,
    input  logic [DATA_WIDTH-1:0] cfg_stride_w,
    input  logic                  idx_ready,
    output logic                  idx_valid,
    output logic [DATA_WIDTH-1:0] idx_c,
    output logic [DATA_WIDTH-1:0] idx_r,
    output logic [DATA_WIDTH-1:0] idx_w,
    output logic                  last_w,
    output logic                  last_all,
    output logic                  busy,
    output logic                  done
);
    localparam logic [DATA_WIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] max_c, max_r, max_w;
    logic [DATA_WIDTH-1:0] stride_c, stride_r, stride_w;
    logic [DATA_WIDTH-1:0] st_c, st_r, st_w;
    logic [DATA_WIDTH:0]   sum_c, sum_r, sum_w;
    logic                  wrap_c, wrap_r, wrap_w;
    logic [DATA_WIDTH-1:0] nxt_c, nxt_r, nxt_w;
    logic                  accept;

    // A zero stride would stall a level forever, so it steps by one instead.
    assign st_c = stride_c == '0 ? ONE : stride_c;
    assign st_r = stride_r == '0 ? ONE : stride_r;
    assign st_w = stride_w == '0 ? ONE : stride_w;

    // One extra bit catches a step that would leave the index range; that
    // step wraps and carries just like reaching max.
    assign sum_c = {1'b0, idx_c} + {1'b0, st_c};
    assign sum_r = {1'b0, idx_r} + {1'b0, st_r};
    assign sum_w = {1'b0, idx_w} + {1'b0, st_w};

    assign wrap_c = idx_c >= max_c || sum_c[DATA_WIDTH];
    assign wrap_r = idx_r >= max_r || sum_r[DATA_WIDTH];
    assign wrap_w = idx_w >= max_w || sum_w[DATA_WIDTH];

    assign nxt_w = wrap_w ? '0 : sum_w[DATA_WIDTH-1:0];
    assign nxt_r = !wrap_w ? idx_r : wrap_r ? '0 : sum_r[DATA_WIDTH-1:0];
    assign nxt_c = !(wrap_w && wrap_r) ? idx_c : wrap_c ? '0 : sum_c[DATA_WIDTH-1:0];

    assign last_w   = wrap_w && idx_valid;
    assign last_all = last_w && wrap_r && wrap_c;
    assign accept   = idx_valid && idx_ready;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = abort ? IDLE : (accept && last_all) ? DONE : RUN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        idx_valid = state == RUN;
        busy      = state == RUN;
        done      = state == DONE;
    end

    // On the final accepted tuple every level wraps, so nxt_* is already zero
    // and the indices come back cleared for the next pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_c    <= '0;
            max_r    <= '0;
            max_w    <= '0;
            stride_c <= '0;
            stride_r <= '0;
            stride_w <= '0;
            idx_c    <= '0;
            idx_r    <= '0;
            idx_w    <= '0;
        end else if (state == IDLE && start) begin
            max_c    <= cfg_max_c;
            max_r    <= cfg_max_r;
            max_w    <= cfg_max_w;
            stride_c <= cfg_stride_c;
            stride_r <= cfg_stride_r;
            stride_w <= cfg_stride_w;
            idx_c    <= '0;
            idx_r    <= '0;
            idx_w    <= '0;
        end else if (state == RUN && abort) begin
            idx_c <= '0;
            idx_r <= '0;
            idx_w <= '0;
        end else if (accept) begin
            idx_c <= nxt_c;
            idx_r <= nxt_r;
            idx_w <= nxt_w;
        end
    end
endmodule

// File: tb/tb_loop_nest_ctrl.sv
// tb_loop_nest_ctrl: randomized scoreboard bench for loop_nest_ctrl
module tb_loop_nest_ctrl;
    localparam int DW  = 4;
    localparam int TOP = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset, start, abort, idx_ready;
    logic [DW-1:0] cfg_max_c, cfg_stride_c, cfg_max_r, cfg_stride_r, cfg_max_w, cfg_stride_w;
    logic          idx_valid, last_w, last_all, busy, done;
    logic [DW-1:0] idx_c, idx_r, idx_w;

    loop_nest_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_max_c(cfg_max_c), .cfg_stride_c(cfg_stride_c),
        .cfg_max_r(cfg_max_r), .cfg_stride_r(cfg_stride_r),
        .cfg_max_w(cfg_max_w), .cfg_stride_w(cfg_stride_w),
        .idx_ready(idx_ready), .idx_valid(idx_valid),
        .idx_c(idx_c), .idx_r(idx_r), .idx_w(idx_w),
        .last_w(last_w), .last_all(last_all), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int r;
        int w;
        bit lw;
        bit la;
    } tup_t;

    tup_t exp_q[$];
    tup_t mon_t;
    int   checks = 0;
    int   failures = 0;
    bit   pending_done = 1'b0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Number of values a level issues: 0, s, 2s, ... while previous < max
    // and the next step stays representable.
    function automatic int level_count(input int mx, input int st);
        int s = st == 0 ? 1 : st;
        int v = 0;
        int n = 1;
        while (v < mx && v + s <= TOP) begin
            v += s;
            n++;
        end
        return n;
    endfunction

    task automatic build_expected(input int mc, sc, mr, sr, mw, sw);
        int nc = level_count(mc, sc);
        int nr = level_count(mr, sr);
        int nw = level_count(mw, sw);
        int ec = sc == 0 ? 1 : sc;
        int er = sr == 0 ? 1 : sr;
        int ew = sw == 0 ? 1 : sw;
        tup_t t;
        for (int ci = 0; ci < nc; ci++)
            for (int ri = 0; ri < nr; ri++)
                for (int wi = 0; wi < nw; wi++) begin
                    t.c  = ci * ec;
                    t.r  = ri * er;
                    t.w  = wi * ew;
                    t.lw = wi == nw - 1;
                    t.la = wi == nw - 1 && ri == nr - 1 && ci == nc - 1;
                    exp_q.push_back(t);
                end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("done", done, pending_done);
            pending_done = 1'b0;
            if (idx_valid && idx_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_tuple got=(%0d,%0d,%0d) exp=none", idx_c, idx_r, idx_w);
                end else begin
                    mon_t = exp_q.pop_front();
                    chk("idx_c", idx_c, mon_t.c);
                    chk("idx_r", idx_r, mon_t.r);
                    chk("idx_w", idx_w, mon_t.w);
                    chk("last_w", last_w, mon_t.lw);
                    chk("last_all", last_all, mon_t.la);
                    pending_done = mon_t.la;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ready always high, 1 ready pattern 1,0,0, 2 random ready.
    // abort_at: number of accepted tuples after which abort is raised (-1 none).
    task automatic run_pass(input int mc, sc, mr, sr, mw, sw, input int mode,
                            input int abort_at, input bit abort_with_start);
        int  n = 0;
        bit  ended = 1'b0;
        bit  aborted = 1'b0;
        build_expected(mc, sc, mr, sr, mw, sw);
        cfg_max_c = DW'(mc); cfg_stride_c = DW'(sc);
        cfg_max_r = DW'(mr); cfg_stride_r = DW'(sr);
        cfg_max_w = DW'(mw); cfg_stride_w = DW'(sw);
        start = 1'b1;
        abort = abort_with_start;
        idx_ready = 1'b0;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        chk("first_valid", idx_valid, 1);
        chk("busy_run", busy, 1);
        for (int k = 0; k < 3000; k++) begin
            if (!idx_valid) begin
                ended = 1'b1;
                break;
            end
            idx_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
            abort = n == abort_at;
            aborted |= abort;
            start = $urandom_range(0, 3) == 0;
            cfg_max_c = DW'($urandom); cfg_stride_c = DW'($urandom);
            cfg_max_r = DW'($urandom); cfg_stride_r = DW'($urandom);
            cfg_max_w = DW'($urandom); cfg_stride_w = DW'($urandom);
            if (idx_ready && !abort) n++;
            cyc();
        end
        start = 1'b0;
        abort = 1'b0;
        if (!ended) begin
            checks++;
            failures++;
            $display("FAIL pass_timeout got=running exp=finished");
        end
        chk("busy_after", busy, 0);
        if (aborted) begin
            chk("abort_idx", {idx_c, idx_r, idx_w}, 0);
            exp_q.delete();
            cyc();
            chk("abort_stays_idle", idx_valid, 0);
        end else begin
            abort = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            cyc();
            abort = 1'b0;
            start = 1'b0;
            chk("done_to_idle", idx_valid, 0);
            chk("queue_empty", exp_q.size(), 0);
            exp_q.delete();
        end
        cyc();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        idx_ready = 1'b0;
        {cfg_max_c, cfg_stride_c, cfg_max_r, cfg_stride_r, cfg_max_w, cfg_stride_w} = '0;
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rst_valid", idx_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_idx", {idx_c, idx_r, idx_w}, 0);
        end
        mon_en = 1'b1;
        run_pass(0, 1, 1, 1, 2, 1, 0, -1, 1'b0);
        run_pass(0, 0, 0, 0, 5, 2, 0, -1, 1'b0);
        run_pass(0, 0, 0, 0, 15, 8, 0, -1, 1'b0);
        run_pass(0, 1, 1, 1, 2, 1, 1, -1, 1'b0);
        run_pass(0, 1, 1, 1, 2, 1, 0, 2, 1'b0);
        run_pass(0, 1, 1, 1, 2, 1, 0, -1, 1'b1);
        run_pass(2, 15, 3, 9, 7, 0, 2, -1, 1'b0);
        for (int p = 0; p < 25; p++)
            run_pass($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 2),
                     $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 10)) : -1,
                     1'($urandom_range(0, 1)));
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
